// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with a retired-instruction counter.
// Optional feature macro RV_ILLEGAL_TRAP_EN: unknown opcodes halt the FSM and raise illegal.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             ALU0,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ImmSrc,
    output logic [3:0]       ALUControl,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // JALRWB is the second JALR cycle that writes OldPC+4 back to rd.
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALRWB, UPPER, HALT
    } state_t;

    state_t     state;
    state_t     next_state;
    state_t     unknown_next;
    logic [3:0] alu_op;
    logic [3:0] branch_alu;
    logic       branch_taken;

`ifdef RV_ILLEGAL_TRAP_EN
    assign unknown_next = HALT;
`else
    assign unknown_next = FETCH;
`endif

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    // funct3 010/011 are not branch encodings: never taken.
    always_comb begin
        branch_alu   = ALU_ADD;
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  begin branch_alu = ALU_SUB;  branch_taken = Zero;  end
            3'b001:  begin branch_alu = ALU_SUB;  branch_taken = !Zero; end
            3'b100:  begin branch_alu = ALU_SLT;  branch_taken = ALU0;  end
            3'b101:  begin branch_alu = ALU_SLT;  branch_taken = !ALU0; end
            3'b110:  begin branch_alu = ALU_SLTU; branch_taken = ALU0;  end
            3'b111:  begin branch_alu = ALU_SLTU; branch_taken = !ALU0; end
            default: begin branch_alu = ALU_ADD;  branch_taken = 1'b0;  end
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_R:              next_state = EXECR;
                    OP_I:              next_state = EXECI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR;
                    OP_LUI, OP_AUIPC:  next_state = UPPER;
                    default:           next_state = unknown_next;
                endcase
            end
            MEMADR: next_state = (op == OP_LOAD) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) next_state = MEMWB;
            MEMWR:  if (mem_ready) next_state = FETCH;
            EXECR, EXECI: next_state = ALUWB;
            JALR:   next_state = JALRWB;
            MEMWB, ALUWB, BRANCH, JAL, JALRWB, UPPER: next_state = FETCH;
            HALT:   next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // Every re-entry into FETCH retires one instruction; a held FETCH does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (next_state == FETCH && state != FETCH)
                instret <= instret + CNT_W'(1);
        end
    end

`ifdef RV_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)
            illegal <= 1'b0;
        else
            illegal <= (next_state == HALT);
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b10;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ResultSrc = 2'b10;
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_op;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_I;
                ALUControl = alu_op;
            end
            ALUWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = branch_alu;
                PCWrite    = branch_taken;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            JALRWB: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
            end
            UPPER: begin
                ImmSrc   = IMM_U;
                RegWrite = 1'b1;
                if (op == OP_LUI) begin
                    ResultSrc = 2'b11;
                end else begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                end
            end
            default: ;
        endcase
        // Reset overrides any in-flight request immediately.
        if (reset) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected control
// sequences, randomized memory latency and flags, plus directed corner cases.
module tb_multicycle_controller;

    localparam int CNT_W = 4;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JALOP  = 7'b1101111;
    localparam logic [6:0] JALROP = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       op = '0;
    logic [2:0]       funct3 = '0;
    logic             funct7b5 = 1'b0;
    logic             Zero = 1'b0;
    logic             ALU0 = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]       ImmSrc;
    logic [3:0]       ALUControl;
    logic [CNT_W-1:0] instret;
    logic             illegal;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .ALU0(ALU0), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .instret(instret), .illegal(illegal)
    );

    // Bit layout: {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
    logic [19:0] dutWord;
    assign dutWord = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

    typedef struct {
        logic [19:0] word;
        logic        mr;
        logic        z;
        logic        a0;
    } step_t;

    step_t       steps[$];
    logic [19:0] seen[$];
    int          checks = 0;
    int          fails = 0;
    int          retired = 0;
    int          haltLen = 3;

    function automatic logic [19:0] w(input logic [5:0] strobes, input logic [1:0] res,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] imm, input logic [3:0] alu,
                                      input logic ill);
        return {strobes, res, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Arithmetic op chosen from funct3 through a lookup, then the funct7b5 variants.
    function automatic logic [3:0] aluFor(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        logic [3:0] tbl [8];
        logic [3:0] r;
        tbl = '{4'b0000, 4'b0111, 4'b0101, 4'b0110, 4'b0100, 4'b1000, 4'b0011, 4'b0010};
        r = tbl[f3];
        if (f3 == 3'b000 && o == RTYPE && f7) r = 4'b0001;
        if (f3 == 3'b101 && f7) r = 4'b1001;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushStep(input logic [19:0] word, input logic mr, input logic z, input logic a0);
        step_t s;
        s.word = word; s.mr = mr; s.z = z; s.a0 = a0;
        steps.push_back(s);
    endtask

    // Expected per-cycle control words for one instruction.
    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input int fw, input int mw, input logic bz, input logic ba,
                                 output bit retires);
        logic       taken;
        logic [3:0] balu;
        retires = 1'b1;
        op = o; funct3 = f3; funct7b5 = f7;
        for (int i = 0; i < fw; i++)
            pushStep(w(6'b100000, 2'b00, 2'b00, 2'b10, 3'b000, 4'h0, 1'b0), 1'b0, rb(), rb());
        pushStep(w(6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0, 1'b0), 1'b1, rb(), rb());
        pushStep(w(6'b000000, 2'b00, 2'b01, 2'b01, (o == JALOP) ? 3'b011 : 3'b010, 4'h0, 1'b0),
                 rb(), rb(), rb());
        case (o)
            LOAD: begin
                pushStep(w(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'h0, 1'b0), rb(), rb(), rb());
                for (int i = 0; i < mw; i++)
                    pushStep(w(6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0), 1'b0, rb(), rb());
                pushStep(w(6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0), 1'b1, rb(), rb());
                pushStep(w(6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0), rb(), rb(), rb());
            end
            STORE: begin
                pushStep(w(6'b000000, 2'b00, 2'b10, 2'b01, 3'b001, 4'h0, 1'b0), rb(), rb(), rb());
                for (int i = 0; i < mw; i++)
                    pushStep(w(6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0), 1'b0, rb(), rb());
                pushStep(w(6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0), 1'b1, rb(), rb());
            end
            RTYPE, ITYPE: begin
                pushStep(w(6'b000000, 2'b00, 2'b10, (o == ITYPE) ? 2'b01 : 2'b00, 3'b000,
                           aluFor(o, f3, f7), 1'b0), rb(), rb(), rb());
                pushStep(w(6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0), rb(), rb(), rb());
            end
            BR: begin
                case (f3)
                    3'b000:  begin taken = bz;  balu = 4'b0001; end
                    3'b001:  begin taken = !bz; balu = 4'b0001; end
                    3'b100:  begin taken = ba;  balu = 4'b0101; end
                    3'b101:  begin taken = !ba; balu = 4'b0101; end
                    3'b110:  begin taken = ba;  balu = 4'b0110; end
                    3'b111:  begin taken = !ba; balu = 4'b0110; end
                    default: begin taken = 1'b0; balu = 4'b0000; end
                endcase
                pushStep(w({4'b0000, taken, 1'b0}, 2'b00, 2'b10, 2'b00, 3'b000, balu, 1'b0), rb(), bz, ba);
            end
            JALOP:
                pushStep(w(6'b000011, 2'b00, 2'b01, 2'b10, 3'b000, 4'h0, 1'b0), rb(), rb(), rb());
            JALROP: begin
                pushStep(w(6'b000010, 2'b10, 2'b10, 2'b01, 3'b000, 4'h0, 1'b0), rb(), rb(), rb());
                pushStep(w(6'b000001, 2'b10, 2'b01, 2'b10, 3'b000, 4'h0, 1'b0), rb(), rb(), rb());
            end
            LUI:
                pushStep(w(6'b000001, 2'b11, 2'b00, 2'b00, 3'b100, 4'h0, 1'b0), rb(), rb(), rb());
            AUIPC:
                pushStep(w(6'b000001, 2'b10, 2'b01, 2'b01, 3'b100, 4'h0, 1'b0), rb(), rb(), rb());
            default: begin
`ifdef RV_ILLEGAL_TRAP_EN
                retires = 1'b0;
                for (int i = 0; i < haltLen; i++)
                    pushStep(w(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b1), rb(), rb(), rb());
`endif
            end
        endcase
    endtask

    // Compare process: one control-word and one counter comparison per cycle.
    task automatic checkOutput();
        step_t s;
        seen.delete();
        while (steps.size() > 0) begin
            s = steps.pop_front();
            mem_ready = s.mr; Zero = s.z; ALU0 = s.a0;
            #1;
            seen.push_back(dutWord);
            check("ctrl_word", 32'(dutWord), 32'(s.word));
            check("instret", 32'(instret), 32'(retired % (1 << CNT_W)));
            @(negedge clk);
        end
    endtask

    task automatic exec(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input int fw, input int mw, input logic bz, input logic ba);
        bit r;
        applyStimulus(o, f3, f7, fw, mw, bz, ba, r);
        checkOutput();
        if (r) retired++;
    endtask

    task automatic doReset();
        reset = 1'b1; mem_ready = 1'b1; Zero = rb(); ALU0 = rb();
        #1;
        check("reset_strobes", 32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        retired = 0;
    endtask

    initial begin
        logic [6:0] opTbl [11];
        int         firstWb;
        bit         r;
        logic [6:0] o;
        logic [2:0] f3;
        opTbl = '{LOAD, STORE, RTYPE, ITYPE, BR, JALOP, JALROP, LUI, AUIPC, 7'b1111111, 7'b0001111};

        @(negedge clk);
        doReset();

        // add x3,x1,x2: RegWrite only in the fourth cycle, one retirement.
        exec(RTYPE, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
        check("add_regwrite_c4", 32'(seen[3][14]), 32'd1);
        check("add_regwrite_early", 32'({seen[0][14], seen[1][14], seen[2][14]}), 32'd0);
        check("add_instret", 32'(instret), 32'd1);

        // lw with 3 fetch wait cycles and 2 load wait cycles retires on cycle 10.
        exec(LOAD, 3'b010, 1'b0, 3, 2, 1'b0, 1'b0);
        firstWb = -1;
        for (int i = seen.size() - 1; i >= 0; i--)
            if (seen[i][14]) firstWb = i;
        check("lw_regwrite_cycle", 32'(firstWb), 32'd9);
        check("lw_no_early_irwrite", 32'({seen[0][16], seen[1][16], seen[2][16]}), 32'd0);
        check("lw_instret", 32'(instret), 32'd2);

        // Branch decisions.
        exec(BR, 3'b001, 1'b0, 0, 0, 1'b1, 1'b0);
        check("bne_zero1_pcwrite", 32'(seen[2][15]), 32'd0);
        exec(BR, 3'b001, 1'b0, 1, 0, 1'b0, 1'b0);
        check("bne_zero0_pcwrite", 32'(seen[3][15]), 32'd1);
        exec(BR, 3'b110, 1'b0, 0, 0, 1'b0, 1'b1);
        check("bltu_alucontrol", 32'(seen[2][4:1]), 32'b0110);
        check("bltu_pcwrite", 32'(seen[2][15]), 32'd1);

        // Reset during a stalled store: request abandoned, counter cleared.
        applyStimulus(STORE, 3'b010, 1'b0, 0, 5, 1'b0, 1'b0, r);
        while (steps.size() > 6) void'(steps.pop_back());
        checkOutput();
        doReset();
        mem_ready = 1'b0;
        #1;
        check("sw_reset_memwrite", 32'(MemWrite), 32'd0);
        check("sw_reset_instret", 32'(instret), 32'd0);
        check("sw_reset_fetch", 32'({mem_req, ALUSrcB}), 32'b110);
        @(negedge clk);
        exec(RTYPE, 3'b100, 1'b0, 1, 0, 1'b0, 1'b0);

        // Unknown opcode.
        doReset();
`ifdef RV_ILLEGAL_TRAP_EN
        haltLen = 20;
        exec(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
        haltLen = 3;
        check("illegal_set", 32'(illegal), 32'd1);
        check("illegal_instret", 32'(instret), 32'd0);
        doReset();
        check("illegal_cleared", 32'(illegal), 32'd0);
`else
        exec(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
        check("nop_instret", 32'(instret), 32'd1);
        check("nop_illegal", 32'(illegal), 32'd0);
        mem_ready = 1'b0;
        #1;
        check("nop_back_to_fetch", 32'({mem_req, AdrSrc, ALUSrcB}), 32'b1010);
        @(negedge clk);
`endif

        // Sixteen ALU instructions wrap a 4-bit counter back to zero.
        doReset();
        for (int i = 0; i < 16; i++)
            exec((i % 2 == 0) ? RTYPE : ITYPE, 3'($urandom_range(0, 7)), rb(),
                 $urandom_range(0, 2), 0, 1'b0, 1'b0);
        check("instret_wrap", 32'(instret), 32'd0);

        // Randomized instruction mix with random latency and flags.
        for (int n = 0; n < 150; n++) begin
            o  = opTbl[$urandom_range(0, 10)];
            f3 = 3'($urandom_range(0, 7));
            applyStimulus(o, f3, rb(), $urandom_range(0, 3), $urandom_range(0, 3), rb(), rb(), r);
            checkOutput();
            if (r) retired++;
            else doReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
